sensor_request_controller: RTL and testbench
============================================

SENSOR_REQUEST_CONTROLLER -- requirements
Module: sensor_request_controller

Interface
REQ-001 The module SHALL have parameter NUM_RETRIES, default 2: extra sensor attempts after a failed attempt.
REQ-002 The module SHALL have parameter TIMEOUT_CYCLES, default 5_000_000: per-attempt watchdog, 100 ms at 50 MHz.
REQ-003 The module SHALL have parameter GUARD_CYCLES, default 50_000_000: minimum sensor idle gap, 1 s at 50 MHz.
REQ-004 The module SHALL have port clock, input, 1 bit: rising-edge clock.
REQ-005 The module SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-006 The module SHALL have ports cmd_valid (input, 1), cmd_ready (output, 1), cmd_address (input, 8) and cmd_code (input, 8), forming the request handshake.
REQ-007 The module SHALL have ports sensor_enable (output, 1), sensor_reset (output, 1) and sensor_address (output, 8), which drive the sensor link.
REQ-008 The module SHALL have ports sensor_hold (input, 1), sensor_error (input, 1), sensor_done (input, 1) and sensor_data (input, 40), which carry sensor link status and data.
REQ-009 The module SHALL have ports resp_valid (output, 1), resp_ready (input, 1), resp_code (output, 8) and resp_value (output, 8), forming the response handshake.
REQ-010 The module SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-011 The module SHALL accept a command on a clock edge only when cmd_valid=1 and cmd_ready=1, and SHALL drive cmd_ready=1 only in IDLE.
REQ-012 On acceptance, the module SHALL latch cmd_address into sensor_address and latch cmd_code.
REQ-013 The module SHALL decode commands as follows: 0x01 status, 0x02 humidity, 0x03 temperature; any other code is invalid.
REQ-014 For an invalid code, the FSM SHALL go IDLE->RESPOND with resp_code=0xEF and resp_value=0x00, with no sensor access and no guard.
REQ-015 The FSM SHALL have states IDLE, START, RUN, CHECK, RETRY, GUARD and RESPOND.
REQ-016 START SHALL last exactly 1 cycle, with sensor_enable=1 and sensor_reset=1; the next state is RUN.
REQ-017 In RUN, the module SHALL drive sensor_enable=1 and sensor_reset=0, and SHALL ignore sensor_done and sensor_error for the first 2 cycles after entry.
REQ-018 In RUN, after those 2 cycles, sensor_done=1 with sensor_hold=0 SHALL move the FSM to CHECK.
REQ-019 In RUN, after those 2 cycles, sensor_error=1 SHALL move the FSM to RETRY, and sensor_error SHALL take priority over sensor_done in the same cycle.
REQ-020 A RUN watchdog SHALL count cycles in RUN, and reaching TIMEOUT_CYCLES SHALL move the FSM to RETRY.
REQ-021 The module SHALL interpret sensor_data fields as: [39:32] humidity integer, [31:24] humidity decimal, [23:16] temperature integer, [15:8] temperature decimal, [7:0] checksum.
REQ-022 CHECK SHALL last 1 cycle and compute the checksum as the 8-bit sum of the four data bytes, with the carry discarded (mod 256).
REQ-023 In CHECK, a checksum match SHALL move the FSM to RESPOND with a success response, and a mismatch SHALL move it to RETRY.
REQ-024 Success responses SHALL be: status gives 0x08/0x00, humidity gives 0x09/[39:32], temperature gives 0x0A/[23:16] (resp_code/resp_value).
REQ-025 In RETRY, if retry_count < NUM_RETRIES, the module SHALL increment retry_count and go to GUARD, then to START.
REQ-026 In RETRY, if retry_count = NUM_RETRIES, the module SHALL go to RESPOND with resp_code=0x1F and resp_value=0x00.
REQ-027 retry_count SHALL be cleared on command acceptance; a command therefore gets at most NUM_RETRIES+1 sensor attempts.
REQ-028 In RESPOND, resp_valid SHALL be held at 1, and resp_code and resp_value SHALL stay stable until resp_ready=1 is sampled.
REQ-029 On the resp_ready handshake edge, resp_valid SHALL return to 0 and the FSM SHALL go to GUARD; for the invalid-code response, the FSM SHALL go to IDLE instead.
REQ-030 GUARD SHALL drive sensor_enable=0 for exactly GUARD_CYCLES cycles and SHALL hold cmd_ready=0 throughout.
REQ-031 Outside START and RUN, the module SHALL drive sensor_enable=0 and sensor_reset=0.
REQ-032 A new cmd_valid SHALL be ignored while busy; no queueing.

Reset
REQ-033 On reset=1 at a clock edge, the module SHALL enter IDLE regardless of its current state, including mid-RUN and mid-RESPOND; any pending response SHALL be discarded.
REQ-034 Reset values SHALL be: cmd_ready=1, busy=0, resp_valid=0, resp_code=0x00, resp_value=0x00, sensor_enable=0, sensor_reset=0, sensor_address=0x00; all counters SHALL be 0.

Verification
REQ-035 The bench SHALL use TIMEOUT_CYCLES=1000 and GUARD_CYCLES=100 for all scenarios below.
REQ-036 Temperature read: cmd 0x03 with sensor model returning data 0x3700190050 -> sensor_reset pulse of 1 cycle, then resp 0x0A/0x19, then 100 guard cycles, then cmd_ready=1.
REQ-037 Checksum failure: data 0x3700190051 on all attempts -> 3 START pulses with 100 guard cycles between them, then resp 0x1F/0x00.
REQ-038 Sensor error then recovery: sensor_error on attempt 1, valid data 0x4000190059 on attempt 2 with cmd 0x02 -> resp 0x09/0x40.
REQ-039 Timeout: sensor_done never asserted -> RETRY after exactly 1000 RUN cycles, then 0x1F after the third attempt.
REQ-040 Invalid code 0x55 -> resp 0xEF/0x00 with sensor_enable never high; reset asserted mid-RUN -> next cycle sensor_enable=0, cmd_ready=1, resp_valid=0.

Source files
------------

// File: rtl/sensor_request_controller_if.sv
// Request/response handshake bundle for sensor_request_controller.
//   cmd_valid/cmd_ready/cmd_address/cmd_code     : command handshake (requester -> controller)
//   resp_valid/resp_ready/resp_code/resp_value   : response handshake (controller -> requester)
// The master modport is the requester side. The slave modport is the controller side.
interface sensor_request_controller_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_address;
  logic [7:0] cmd_code;
  logic       resp_valid;
  logic       resp_ready;
  logic [7:0] resp_code;
  logic [7:0] resp_value;

  modport master (
    output cmd_valid, cmd_address, cmd_code, resp_ready,
    input  cmd_ready, resp_valid, resp_code, resp_value
  );

  modport slave (
    input  cmd_valid, cmd_address, cmd_code, resp_ready,
    output cmd_ready, resp_valid, resp_code, resp_value
  );
endinterface

// File: rtl/sensor_request_controller.sv
// Sensor request controller.
// The controller accepts one command at a time and runs up to NUM_RETRIES+1
// sensor attempts. Each attempt has a reset pulse and a watchdog-bounded RUN
// phase, followed by a checksum check. Between attempts, and after a
// sensor-backed response, the sensor link is held idle for GUARD_CYCLES.
// Ports:
//   clock, reset        : rising-edge clock, synchronous active-high reset
//   bus (slave)         : cmd_* request handshake and resp_* response handshake
//   sensor_enable/reset : sensor link drive
//   sensor_address      : address latched from the accepted command
//   sensor_hold/error/done/data : sensor link status and 40-bit frame
//   busy                : high whenever the FSM is outside IDLE
module sensor_request_controller #(
  parameter int NUM_RETRIES    = 2,
  parameter int TIMEOUT_CYCLES = 5_000_000,
  parameter int GUARD_CYCLES   = 50_000_000
) (
  input  logic                        clock,
  input  logic                        reset,
  sensor_request_controller_if.slave  bus,
  output logic                        sensor_enable,
  output logic                        sensor_reset,
  output logic [7:0]                  sensor_address,
  input  logic                        sensor_hold,
  input  logic                        sensor_error,
  input  logic                        sensor_done,
  input  logic [39:0]                 sensor_data,
  output logic                        busy
);

  localparam int RUN_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GUARD_W = $clog2(GUARD_CYCLES + 1);
  localparam int RETRY_W = (NUM_RETRIES > 0) ? $clog2(NUM_RETRIES + 1) : 1;

  localparam logic [RUN_W-1:0]   RUN_LAST   = RUN_W'(TIMEOUT_CYCLES - 1);
  localparam logic [RUN_W-1:0]   RUN_SETTLE = RUN_W'(2);
  localparam logic [GUARD_W-1:0] GUARD_LAST = GUARD_W'(GUARD_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX  = RETRY_W'(NUM_RETRIES);

  localparam logic [7:0] CODE_STATUS   = 8'h01;
  localparam logic [7:0] CODE_HUMIDITY = 8'h02;
  localparam logic [7:0] CODE_TEMP     = 8'h03;
  localparam logic [7:0] RESP_STATUS   = 8'h08;
  localparam logic [7:0] RESP_HUMIDITY = 8'h09;
  localparam logic [7:0] RESP_TEMP     = 8'h0A;
  localparam logic [7:0] RESP_FAIL     = 8'h1F;
  localparam logic [7:0] RESP_INVALID  = 8'hEF;

  typedef enum logic [2:0] {IDLE, START, RUN, CHECK, RETRY, GUARD, RESPOND} state_t;

  state_t               state, state_next;
  logic [7:0]           cmd_code_q;
  logic [RETRY_W-1:0]   retry_count;
  logic [RUN_W-1:0]     run_count;
  logic [GUARD_W-1:0]   guard_count;
  logic                 guard_retry;   // GUARD leads back to START rather than IDLE
  logic                 resp_valid_q;
  logic [7:0]           resp_code_q;
  logic [7:0]           resp_value_q;
  logic [39:0]          data_q;
  logic                 cmd_ready_c;
  logic                 settled;
  logic                 sum_ok;

  function automatic logic [7:0] frame_checksum(input logic [39:0] d);
    return d[39:32] + d[31:24] + d[23:16] + d[15:8];
  endfunction

  function automatic logic code_known(input logic [7:0] c);
    return (c == CODE_STATUS) || (c == CODE_HUMIDITY) || (c == CODE_TEMP);
  endfunction

  assign settled        = (run_count >= RUN_SETTLE);
  assign sum_ok         = (frame_checksum(data_q) == data_q[7:0]);
  assign bus.cmd_ready  = cmd_ready_c;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_code  = resp_code_q;
  assign bus.resp_value = resp_value_q;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next    = state;
    cmd_ready_c   = 1'b0;
    sensor_enable = 1'b0;
    sensor_reset  = 1'b0;
    busy          = 1'b1;
    case (state)
      IDLE: begin
        cmd_ready_c = 1'b1;
        busy        = 1'b0;
        if (bus.cmd_valid) state_next = code_known(bus.cmd_code) ? START : RESPOND;
      end
      START: begin
        sensor_enable = 1'b1;
        sensor_reset  = 1'b1;
        state_next    = RUN;
      end
      RUN: begin
        sensor_enable = 1'b1;
        // Error beats done. The watchdog fires only when nothing else happened.
        if (settled && sensor_error)                    state_next = RETRY;
        else if (settled && sensor_done && !sensor_hold) state_next = CHECK;
        else if (run_count == RUN_LAST)                 state_next = RETRY;
      end
      CHECK:   state_next = sum_ok ? RESPOND : RETRY;
      RETRY:   state_next = (retry_count < RETRY_MAX) ? GUARD : RESPOND;
      GUARD:   if (guard_count == GUARD_LAST) state_next = guard_retry ? START : IDLE;
      RESPOND: if (bus.resp_ready) state_next = code_known(cmd_code_q) ? GUARD : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sensor_address <= 8'h00;
      cmd_code_q     <= 8'h00;
      retry_count    <= '0;
      run_count      <= '0;
      guard_count    <= '0;
      guard_retry    <= 1'b0;
      resp_valid_q   <= 1'b0;
      resp_code_q    <= 8'h00;
      resp_value_q   <= 8'h00;
    end else begin
      case (state)
        IDLE: if (bus.cmd_valid) begin
          sensor_address <= bus.cmd_address;
          cmd_code_q     <= bus.cmd_code;
          retry_count    <= '0;
          if (!code_known(bus.cmd_code)) begin
            resp_valid_q <= 1'b1;
            resp_code_q  <= RESP_INVALID;
            resp_value_q <= 8'h00;
          end
        end
        START: run_count <= '0;
        RUN:   run_count <= run_count + 1'b1;
        CHECK: if (sum_ok) begin
          resp_valid_q <= 1'b1;
          case (cmd_code_q)
            CODE_HUMIDITY: begin resp_code_q <= RESP_HUMIDITY; resp_value_q <= data_q[39:32]; end
            CODE_TEMP:     begin resp_code_q <= RESP_TEMP;     resp_value_q <= data_q[23:16]; end
            default:       begin resp_code_q <= RESP_STATUS;   resp_value_q <= 8'h00;         end
          endcase
        end
        RETRY: begin
          if (retry_count < RETRY_MAX) begin
            retry_count <= retry_count + 1'b1;
            guard_retry <= 1'b1;
            guard_count <= '0;
          end else begin
            resp_valid_q <= 1'b1;
            resp_code_q  <= RESP_FAIL;
            resp_value_q <= 8'h00;
          end
        end
        GUARD: guard_count <= guard_count + 1'b1;
        RESPOND: if (bus.resp_ready) begin
          resp_valid_q <= 1'b0;
          guard_retry  <= 1'b0;
          guard_count  <= '0;
        end
        default: ;
      endcase
    end
  end

  // The frame is captured every RUN cycle, so CHECK sees the frame present when done was taken.
  always_ff @(posedge clock) begin
    if (state == RUN) data_q <= sensor_data;
  end

endmodule

// File: tb/tb_sensor_request_controller.sv
module tb_sensor_request_controller;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        sensor_enable, sensor_reset, busy;
  logic [7:0]  sensor_address;
  logic        sensor_hold  = 1'b0;
  logic        sensor_error = 1'b0;
  logic        sensor_done  = 1'b0;
  logic [39:0] sensor_data  = 40'h0;

  int checks   = 0;
  int failures = 0;

  // sensor model configuration (written by the stimulus block only)
  bit model_silent = 1'b0;
  int model_err_at = -1;
  // sensor model state (written by the model only)
  int attempt = 0;
  int delay   = 0;
  bit active  = 1'b0;

  sensor_request_controller_if bus ();

  sensor_request_controller #(
    .NUM_RETRIES(2), .TIMEOUT_CYCLES(1000), .GUARD_CYCLES(100)
  ) dut (
    .clock(clock), .reset(reset), .bus(bus),
    .sensor_enable(sensor_enable), .sensor_reset(sensor_reset),
    .sensor_address(sensor_address), .sensor_hold(sensor_hold),
    .sensor_error(sensor_error), .sensor_done(sensor_done),
    .sensor_data(sensor_data), .busy(busy)
  );

  always #5 clock = ~clock;

  // Sensor model: a one-cycle done/error pulse on the third RUN cycle of each attempt.
  always @(negedge clock) begin
    if (sensor_reset) begin
      attempt      = attempt + 1;
      delay        = 0;
      active       = 1'b1;
      sensor_done  = 1'b0;
      sensor_error = 1'b0;
    end else if (active && sensor_enable) begin
      delay        = delay + 1;
      sensor_done  = 1'b0;
      sensor_error = 1'b0;
      if (delay == 3 && !model_silent) begin
        if (attempt == model_err_at) sensor_error = 1'b1;
        else                         sensor_done  = 1'b1;
      end
    end else begin
      active       = 1'b0;
      sensor_done  = 1'b0;
      sensor_error = 1'b0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input logic [7:0] addr, input logic [7:0] code);
    bus.cmd_address = addr;
    bus.cmd_code    = code;
    bus.cmd_valid   = 1'b1;
    tick();
    bus.cmd_valid   = 1'b0;
  endtask

  // Observe one cycle per iteration until resp_valid, collecting link statistics.
  task automatic watch(input int max_cycles, output int starts, output int last_run,
                       output int last_gap, output int en_cycles, output logic timed_out);
    int run_len;
    int gap;
    run_len = 0; gap = 0;
    starts = 0; last_run = 0; last_gap = 0; en_cycles = 0; timed_out = 1'b0;
    for (int n = 0; bus.resp_valid !== 1'b1; n++) begin
      if (n >= max_cycles) begin timed_out = 1'b1; break; end
      if (sensor_reset) begin starts++; last_gap = gap; end
      if (sensor_enable) begin en_cycles++; gap = 0; end
      else gap++;
      if (sensor_enable && !sensor_reset) run_len++;
      else if (run_len != 0) begin last_run = run_len; run_len = 0; end
      tick();
    end
  endtask

  task automatic handshake();
    bus.resp_ready = 1'b1;
    tick();
    bus.resp_ready = 1'b0;
  endtask

  task automatic wait_ready(output int cycles, output int en_seen);
    cycles = 0; en_seen = 0;
    while (bus.cmd_ready !== 1'b1 && cycles < 1000) begin
      if (sensor_enable) en_seen++;
      tick();
      cycles++;
    end
  endtask

  initial begin
    int starts, last_run, last_gap, en_cycles, guard_n, guard_en;
    logic to;
    bus.cmd_valid = 1'b0; bus.cmd_address = 8'h00; bus.cmd_code = 8'h00; bus.resp_ready = 1'b0;
    tick(); tick();
    check("rst_cmd_ready", bus.cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_resp_valid", bus.resp_valid, 0);
    check("rst_resp_code", bus.resp_code, 8'h00);
    check("rst_resp_value", bus.resp_value, 8'h00);
    check("rst_sensor_enable", sensor_enable, 0);
    check("rst_sensor_reset", sensor_reset, 0);
    check("rst_sensor_address", sensor_address, 8'h00);
    reset = 1'b0;
    tick();

    // temperature read
    sensor_data = 40'h37_00_19_00_50;
    send_cmd(8'h5A, 8'h03);
    check("temp_busy", busy, 1);
    check("temp_cmd_ready", bus.cmd_ready, 0);
    check("temp_address", sensor_address, 8'h5A);
    watch(500, starts, last_run, last_gap, en_cycles, to);
    check("temp_wait", to, 0);
    check("temp_reset_pulses", starts, 1);
    check("temp_resp_code", bus.resp_code, 8'h0A);
    check("temp_resp_value", bus.resp_value, 8'h19);
    tick(); tick();
    check("temp_hold_valid", bus.resp_valid, 1);
    check("temp_hold_value", bus.resp_value, 8'h19);
    handshake();
    check("temp_valid_drop", bus.resp_valid, 0);
    wait_ready(guard_n, guard_en);
    check("temp_guard_len", guard_n, 100);
    check("temp_guard_enable", guard_en, 0);

    // checksum failure on all attempts
    sensor_data = 40'h37_00_19_00_51;
    send_cmd(8'h11, 8'h03);
    watch(2000, starts, last_run, last_gap, en_cycles, to);
    check("csum_wait", to, 0);
    check("csum_starts", starts, 3);
    check("csum_gap", last_gap, 102);
    check("csum_resp_code", bus.resp_code, 8'h1F);
    check("csum_resp_value", bus.resp_value, 8'h00);
    // a command offered while busy is ignored
    bus.cmd_code = 8'h55; bus.cmd_valid = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    check("busy_ignore_code", bus.resp_code, 8'h1F);
    check("busy_ignore_valid", bus.resp_valid, 1);
    handshake();
    wait_ready(guard_n, guard_en);
    check("csum_guard_len", guard_n, 100);

    // sensor error then recovery
    sensor_data  = 40'h40_00_19_00_59;
    model_err_at = attempt + 1;
    send_cmd(8'h22, 8'h02);
    watch(2000, starts, last_run, last_gap, en_cycles, to);
    check("err_wait", to, 0);
    check("err_starts", starts, 2);
    check("err_gap", last_gap, 101);
    check("err_resp_code", bus.resp_code, 8'h09);
    check("err_resp_value", bus.resp_value, 8'h40);
    handshake();
    wait_ready(guard_n, guard_en);
    model_err_at = -1;

    // watchdog timeout on every attempt
    model_silent = 1'b1;
    send_cmd(8'h33, 8'h01);
    watch(5000, starts, last_run, last_gap, en_cycles, to);
    check("tmo_wait", to, 0);
    check("tmo_run_len", last_run, 1000);
    check("tmo_starts", starts, 3);
    check("tmo_gap", last_gap, 101);
    check("tmo_resp_code", bus.resp_code, 8'h1F);
    check("tmo_resp_value", bus.resp_value, 8'h00);
    handshake();
    wait_ready(guard_n, guard_en);
    model_silent = 1'b0;

    // invalid code
    send_cmd(8'h44, 8'h55);
    watch(50, starts, last_run, last_gap, en_cycles, to);
    check("inv_wait", to, 0);
    check("inv_enable_cycles", en_cycles, 0);
    check("inv_resp_code", bus.resp_code, 8'hEF);
    check("inv_resp_value", bus.resp_value, 8'h00);
    handshake();
    check("inv_cmd_ready", bus.cmd_ready, 1);
    check("inv_busy", busy, 0);

    // reset asserted mid-RUN
    model_silent = 1'b1;
    send_cmd(8'h66, 8'h03);
    tick(); tick(); tick();
    check("midrun_enable", sensor_enable, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrun_rst_enable", sensor_enable, 0);
    check("midrun_rst_cmd_ready", bus.cmd_ready, 1);
    check("midrun_rst_resp_valid", bus.resp_valid, 0);
    check("midrun_rst_address", sensor_address, 8'h00);
    model_silent = 1'b0;

    // reset asserted mid-RESPOND discards the response
    send_cmd(8'h77, 8'h99);
    check("midresp_valid", bus.resp_valid, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midresp_rst_valid", bus.resp_valid, 0);
    check("midresp_rst_code", bus.resp_code, 8'h00);
    check("midresp_rst_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
